// File: rtl/mag_cmp_serial.sv
// Bit-serial MSB-first magnitude comparator with unsigned/two's-complement modes,
// start/busy/done handshake and a wrapping count of completed comparisons.
module mag_cmp_serial #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             start,
   input  logic             signed_mode,
   input  logic             bit_valid,
   input  logic             a_bit,
   input  logic             b_bit,
   output logic             busy,
   output logic             done,
   output logic             result_valid,
   output logic             gt,
   output logic             eq,
   output logic             lt,
   output logic [CNT_W-1:0] cmp_count
);

   localparam int BW = $clog2(WIDTH);

   typedef enum logic {IDLE, SHIFT} state_t;
   typedef enum logic [1:0] {REL_EQ, REL_GT, REL_LT} rel_t;

   state_t        state, state_nxt;
   rel_t          rel, rel_nxt;
   logic [BW-1:0] bit_cnt;
   logic          decided;
   logic          sgn;
   logic          accept_start;
   logic          consume;
   logic          last_bit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   state <= IDLE;
      else if (ena) state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      accept_start = 1'b0;
      consume      = 1'b0;
      last_bit     = 1'b0;
      rel_nxt      = rel;
      case (state)
         IDLE: begin
            if (start) begin
               accept_start = 1'b1;
               state_nxt    = SHIFT;
            end
         end
         SHIFT: begin
            if (bit_valid) begin
               consume  = 1'b1;
               last_bit = (bit_cnt == BW'(WIDTH - 1));
               if (last_bit) state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // Sign bit weighs negative in two's complement, so its verdict flips.
      if (consume && !decided && (a_bit != b_bit))
         rel_nxt = (a_bit ^ (sgn && (bit_cnt == '0))) ? REL_GT : REL_LT;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt      <= '0;
         decided      <= 1'b0;
         rel          <= REL_EQ;
         sgn          <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         result_valid <= 1'b0;
         gt           <= 1'b0;
         eq           <= 1'b0;
         lt           <= 1'b0;
         cmp_count    <= '0;
      end else if (!ena) begin
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept_start) begin
            bit_cnt <= '0;
            decided <= 1'b0;
            rel     <= REL_EQ;
            sgn     <= signed_mode;
            busy    <= 1'b1;
         end
         if (consume) begin
            bit_cnt <= bit_cnt + BW'(1);
            rel     <= rel_nxt;
            if (rel_nxt != REL_EQ) decided <= 1'b1;
            if (last_bit) begin
               busy         <= 1'b0;
               done         <= 1'b1;
               result_valid <= 1'b1;
               gt           <= (rel_nxt == REL_GT);
               eq           <= (rel_nxt == REL_EQ);
               lt           <= (rel_nxt == REL_LT);
               cmp_count    <= cmp_count + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_mag_cmp_serial.sv
// Scoreboard bench: an 8-bit instance for directed/random runs and a 2-bit,
// 2-bit-counter instance for the exhaustive sweep and counter wrap.
module tb_mag_cmp_serial;

   logic clk = 1'b0, rst_n = 1'b0, ena = 1'b0;
   logic signed_mode = 1'b0, bit_valid = 1'b0, a_bit = 1'b0, b_bit = 1'b0;
   logic s8 = 1'b0, s2 = 1'b0;
   logic b8, d8, v8, g8, e8, l8;
   logic b2, d2, v2, g2, e2, l2;
   logic [7:0] c8;
   logic [1:0] c2;

   int n_chk = 0, n_err = 0;
   int cnt8 = 0, cnt2 = 0;
   logic [10:0] q8[$];
   logic [4:0]  q2[$];
   logic [10:0] x8;
   logic [4:0]  x2;

   always #5 clk = ~clk;

   mag_cmp_serial #(.WIDTH(8), .CNT_W(8)) u8 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(s8), .signed_mode(signed_mode),
      .bit_valid(bit_valid), .a_bit(a_bit), .b_bit(b_bit), .busy(b8), .done(d8),
      .result_valid(v8), .gt(g8), .eq(e8), .lt(l8), .cmp_count(c8));

   mag_cmp_serial #(.WIDTH(2), .CNT_W(2)) u2 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(s2), .signed_mode(signed_mode),
      .bit_valid(bit_valid), .a_bit(a_bit), .b_bit(b_bit), .busy(b2), .done(d2),
      .result_valid(v2), .gt(g2), .eq(e2), .lt(l2), .cmp_count(c2));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, act, exp);
      end
   endtask

   // Arithmetic reference: {gt,eq,lt} from integer values of the operands.
   function automatic logic [2:0] ref_rel(input int w, input logic [7:0] a,
                                          input logic [7:0] b, input logic sm);
      int va, vb;
      va = int'(a);
      vb = int'(b);
      if (sm && a[w-1]) va -= (1 << w);
      if (sm && b[w-1]) vb -= (1 << w);
      return {va > vb, va == vb, va < vb};
   endfunction

   always @(negedge clk) begin
      if (d8) begin
         if (q8.size() == 0) chk("u8_spurious_done", 1, 0);
         else begin
            x8 = q8.pop_front();
            chk("u8_result", {g8, e8, l8, c8}, x8);
         end
         chk("u8_result_valid", v8, 1);
      end
      if (d2) begin
         if (q2.size() == 0) chk("u2_spurious_done", 1, 0);
         else begin
            x2 = q2.pop_front();
            chk("u2_result", {g2, e2, l2, c2}, x2);
         end
         chk("u2_result_valid", v2, 1);
      end
   end

   // One comparison. gap: % chance of an idle cycle; pause_at: bit index where ena
   // drops for 3 cycles; poke_at: bit index where start is re-pulsed; abort_at:
   // number of consumed bits after which reset is asserted (-1 = never).
   task automatic run_cmp(input bit sel, input logic [7:0] a, input logic [7:0] b,
                          input logic sm, input int gap, input int pause_at,
                          input int poke_at, input int abort_at);
      int w, i;
      bit paused;
      logic [2:0] r;
      string p;
      w = sel ? 2 : 8;
      p = sel ? "u2" : "u8";
      paused = 1'b0;
      if (abort_at < 0) begin
         r = ref_rel(w, a, b, sm);
         if (sel) begin cnt2++; q2.push_back({r, 2'(cnt2)}); end
         else     begin cnt8++; q8.push_back({r, 8'(cnt8)}); end
      end
      signed_mode = sm;
      bit_valid   = 1'b1;
      a_bit       = 1'($urandom);
      b_bit       = 1'($urandom);
      if (sel) s2 = 1'b1; else s8 = 1'b1;
      @(posedge clk); #1;
      s2 = 1'b0; s8 = 1'b0;
      signed_mode = ~sm;
      chk({p, "_busy_after_start"}, sel ? b2 : b8, 1);
      i = w - 1;
      while (i >= 0) begin
         if (i == pause_at && !paused) begin
            paused    = 1'b1;
            ena       = 1'b0;
            bit_valid = 1'b1;
            a_bit     = ~a[i];
            b_bit     = a[i];
            s8 = 1'b1; s2 = 1'b1;
            repeat (3) begin
               @(posedge clk); #1;
               chk({p, "_busy_frozen"}, sel ? b2 : b8, 1);
            end
            s8 = 1'b0; s2 = 1'b0;
            ena = 1'b1;
         end
         if (abort_at == w - 1 - i) begin
            bit_valid = 1'b0;
            rst_n = 1'b0;
            #1;
            chk("u8_abort_state", {b8, d8, v8, g8, e8, l8, c8}, 0);
            chk("u2_abort_state", {b2, d2, v2, g2, e2, l2, c2}, 0);
            @(posedge clk); #1;
            rst_n = 1'b1;
            cnt8 = 0;
            cnt2 = 0;
            @(posedge clk); #1;
            chk({p, "_no_done_after_abort"}, sel ? d2 : d8, 0);
            return;
         end
         if (gap > 0 && $urandom_range(99) < gap) begin
            bit_valid = 1'b0;
            a_bit = 1'($urandom);
            b_bit = 1'($urandom);
         end else begin
            bit_valid = 1'b1;
            a_bit = a[i];
            b_bit = b[i];
            i--;
         end
         if (sel) s2 = (i == poke_at); else s8 = (i == poke_at);
         @(posedge clk); #1;
         if (i >= 0) begin
            chk({p, "_done_early"}, sel ? d2 : d8, 0);
            chk({p, "_busy_mid"}, sel ? b2 : b8, 1);
         end
      end
      s2 = 1'b0; s8 = 1'b0;
      bit_valid = 1'b0;
      chk({p, "_done_at_end"}, sel ? d2 : d8, 1);
      chk({p, "_busy_at_end"}, sel ? b2 : b8, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      ena   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("u8_reset", {b8, d8, v8, g8, e8, l8, c8}, 0);
      chk("u2_reset", {b2, d2, v2, g2, e2, l2, c2}, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_cmp(0, 8'hA5, 8'h5A, 1'b0, 0, -1, -1, -1);
      run_cmp(0, 8'h3C, 8'h3C, 1'b0, 0, -1, -1, -1);
      run_cmp(0, 8'h80, 8'h7F, 1'b1, 0, -1, -1, -1);
      run_cmp(0, 8'h80, 8'h7F, 1'b0, 0, -1, -1, -1);
      run_cmp(0, 8'hFF, 8'h01, 1'b1, 0, -1, -1, -1);
      run_cmp(0, 8'hA5, 8'h5A, 1'b0, 30, 4, -1, -1);
      run_cmp(0, 8'h80, 8'h7F, 1'b1, 40, 6, -1, -1);
      run_cmp(0, 8'h12, 8'h13, 1'b0, 0, -1, 3, -1);
      run_cmp(0, 8'hA5, 8'h5A, 1'b0, 0, -1, -1, 4);
      run_cmp(0, 8'hA5, 8'h5A, 1'b0, 0, -1, -1, -1);
      repeat (6)
         run_cmp(0, 8'($urandom), 8'($urandom), 1'($urandom), 20, -1, -1, -1);

      for (int s = 0; s < 2; s++)
         for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
               run_cmp(1, 8'(a), 8'(b), s[0], 0, -1, -1, -1);

      repeat (3) @(posedge clk);
      #1;
      chk("u8_queue_drained", q8.size(), 0);
      chk("u2_queue_drained", q2.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/mag_cmp_serial.md
# mag_cmp_serial

Parametrised bit-serial magnitude comparator. It is the sequential successor to the 2-bit combinational comparator in the `tt_um_BMSCE_project_1` wrapper. Two WIDTH-bit operands stream in MSB-first, one bit pair per accepted cycle. The block reports A>B / A=B / A<B in unsigned or two's-complement mode, with a start/busy/done handshake and a wrapping completion counter. It sits behind the TinyTapeout pin wrapper: serial bits and control arrive on `ui_in`, and results go out on `uo_out`.

## Interface
- `WIDTH`, 8: operand width in bits; legal range 2..32.
- `CNT_W`, 8: width of completed-comparison counter.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `ena`  in  1  design enable; low freezes all state.
- `start`  in  1  begin a comparison; sampled only in IDLE.
- `signed_mode`  in  1  0 = unsigned, 1 = two's complement; latched on accepted start.
- `bit_valid`  in  1  `a_bit`/`b_bit` carry a valid bit pair this cycle.
- `a_bit`  in  1  serial operand A, MSB first.
- `b_bit`  in  1  serial operand B, MSB first.
- `busy`  out  1  high from accepted start until the final bit is consumed.
- `done`  out  1  single-cycle pulse when the result updates.
- `result_valid`  out  1  sticky; high after the first completed comparison.
- `gt`, `eq`, `lt`  out  1 each  registered result; exactly one high when `result_valid`=1.
- `cmp_count`  out  CNT_W  number of completed comparisons, modulo 2^CNT_W.

## Operation
- FSM states: IDLE, SHIFT.
  - IDLE -> SHIFT on `start`=1 (with `ena`=1).
  - SHIFT -> IDLE on acceptance of the WIDTH-th valid bit.
- On accepted start:
  - bit counter clears to 0.
  - Internal decided flag clears, and the internal relation clears to "equal".
  - `signed_mode` is latched.
  - `bit_valid` in the start cycle is ignored.
- In SHIFT, each cycle with `bit_valid`=1 consumes one bit pair and increments the bit counter.
  - First differing pair decides the relation and sets the decided flag. Later bits are still consumed but cannot change the relation.
  - Unsigned: a_bit=1, b_bit=0 means A>B; a_bit=0, b_bit=1 means A<B.
  - Signed: the relation is inverted for the first (sign) bit only. Remaining bits use the unsigned rule.
  - Neither bit differs across all WIDTH bits: relation is A=B.
- Gaps (`bit_valid`=0) in SHIFT stall without effect. There is no timeout.
- On the final bit:
  - `gt`/`eq`/`lt` are loaded from the final relation.
  - `done` pulses, `busy` falls, `result_valid` sets, and `cmp_count` increments, wrapping from all-ones to 0.
- Results hold until the next completion; a new start does not clear them.
- `start` in SHIFT is ignored. `bit_valid` in IDLE is ignored.
- `ena`=0: no state, counter, or output register changes. `done` is forced low. Resuming `ena` continues from the frozen state.
- Reset values: `busy`=0, `done`=0, `result_valid`=0, `gt`=`eq`=`lt`=0, `cmp_count`=0, FSM=IDLE.
- Reset asserted mid-operation aborts it. No `done` is issued and the partial result is discarded.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Accepted start at edge k gives `busy`=1 after k.
- With back-to-back bits on edges k+1..k+WIDTH:
  - `done`=1, `busy`=0, and updated results appear after edge k+WIDTH, for exactly one cycle of `done`.
  - Minimum comparison period is WIDTH+1 cycles.
- `start` may be asserted in the same cycle `done` is high, because the FSM is already IDLE. The next comparison then begins at the following edge.
- `rst_n` deassertion is synchronised externally. The block requires no special release handling beyond the async clear.

## Test plan
- Unsigned, WIDTH=8: A=0xA5, B=0x5A, back-to-back bits -> `done` 9 cycles after start; `gt`=1, `eq`=0, `lt`=0; `cmp_count`=1.
- Equal and exhaustive: A=B=0x3C -> `eq`=1. Exhaustive 2-bit sweep (WIDTH=2, all 16 pairs) -> matches the reference comparator truth table.
- Signed versus unsigned: A=0x80, B=0x7F:
  - `signed_mode`=1 -> `lt`=1.
  - Repeat with `signed_mode`=0 -> `gt`=1.
  - Also A=0xFF, B=0x01 signed -> `lt`=1.
- Gaps and ena:
  - Random `bit_valid` gaps plus `ena` low for 3 cycles mid-stream -> same result as the gap-free run. `done` is issued only after 8 valid bits.
  - `start` pulsed during SHIFT -> ignored.
- Reset mid-operation: assert `rst_n`=0 after 4 bits -> all outputs at reset values and no `done`. A subsequent full comparison is correct with `cmp_count`=1.
- Counter wrap: CNT_W=2, five back-to-back comparisons with `start` issued in each `done` cycle -> `cmp_count` sequence 1, 2, 3, 0, 1.
